summult: RTL and testbench
==========================

SUMMULT -- requirements
Module: summult

Interface
REQ-001 The parameter WIDTH SHALL default to 16 and set the bit width of each tap and of each real or imaginary component.
REQ-002 The parameter MWIDTH SHALL default to 1 and set the width of the sideband metadata.
REQ-003 The parameter N SHALL default to 4 and set the number of product terms (taps), N>=1.
REQ-004 Port clk SHALL be an input, 1 bit wide, and act as the clock; rst_n SHALL be an input, 1 bit wide, and act as the reset, synchronous and active-low.
REQ-005 Port in_nd SHALL be an input, 1 bit wide, that flags a valid input set this cycle.
REQ-006 Port in_m SHALL be an input, MWIDTH bits wide, carrying metadata that travels with the sample.
REQ-007 Port in_xs SHALL be an input, N*2*WIDTH bits wide; complex x_i = in_xs[(i+1)*2*WIDTH-1 -: 2*WIDTH], with real in the upper WIDTH bits and imaginary in the lower WIDTH bits.
REQ-008 Port in_ys SHALL be an input, N*WIDTH bits wide; real signed tap y_i = in_ys[(i+1)*WIDTH-1 -: WIDTH].
REQ-009 Port out_data SHALL be an output, 2*WIDTH bits wide, holding the complex result {real, imag}.
REQ-010 Port out_nd SHALL be an output, 1 bit wide, that flags out_data/out_m valid.
REQ-011 Port out_m SHALL be an output, MWIDTH bits wide, holding the in_m delayed alongside its result.
REQ-012 Port overflow SHALL be an output, 1 bit wide, acting as a sticky overflow flag.

Function
REQ-013 For each valid input, real = sum_i(Re(x_i)*y_i) and imag = sum_i(Im(x_i)*y_i), all operands two's-complement signed.
REQ-014 Products and sums SHALL be computed exactly at full precision (2*WIDTH+ceil(log2 N) bits) with no intermediate loss.
REQ-015 Taps are Q1.(WIDTH-1): each full sum SHALL be arithmetically shifted right by WIDTH-1 (truncate toward minus infinity) to form the WIDTH-bit result.
REQ-016 Latency SHALL be exactly 2 cycles: an input sampled with in_nd=1 at edge k appears with out_nd=1 after edge k+2.
REQ-017 The pipeline SHALL accept in_nd on every cycle (throughput 1/cycle, no backpressure); back-to-back inputs SHALL produce back-to-back outputs in order.
REQ-018 out_m SHALL equal the in_m sampled with the same input, delayed identically.
REQ-019 out_nd SHALL be 1 for exactly one cycle per accepted input; when out_nd=0, out_data and out_m SHALL hold their last values.
REQ-020 If a shifted real or imag result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], overflow SHALL go to 1 in the cycle that result is output and stay 1 until reset.
REQ-021 Inputs with in_nd=0 SHALL NOT affect outputs or overflow.

Reset
REQ-022 While rst_n=0 at a clock edge, out_nd, out_data, out_m and overflow SHALL be 0 and all pipeline valid flags SHALL be cleared.
REQ-023 Inputs in flight when reset is asserted SHALL be discarded and never produce out_nd.
REQ-024 in_nd sampled while rst_n=0 SHALL be ignored; the first input accepted after release yields out_nd 2 cycles later.

Configuration
REQ-025 With macro SUMMULT_SATURATE_EN defined, an out-of-range component SHALL be clamped to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
REQ-026 Without SUMMULT_SATURATE_EN, an out-of-range component SHALL be the low WIDTH bits of the shifted result (wrap); overflow reporting is identical in both builds.

Verification (WIDTH=16, N=4, MWIDTH=1)
REQ-027 Apply all x_i=(1000,-2000), all y_i=16384, in_m=1, one in_nd pulse -> 2 cycles later out_nd=1, out_data={2000,-4000}, out_m=1, overflow=0.
REQ-028 Apply x_0=(-1,1), y_0=1, other taps 0 -> result real=-1, imag=0 (floor truncation).
REQ-029 Apply all x_i=(32767,0), all y_i=32767 -> overflow=1 and stays 1; the real result is 32767 with SUMMULT_SATURATE_EN defined, or the wrapped low 16 bits without it.
REQ-030 Assert in_nd for 3 consecutive cycles with distinct data and in_m=1,0,1 -> 3 consecutive out_nd pulses in order with matching results and out_m values.
REQ-031 Assert in_nd, then rst_n=0 on the next cycle -> no out_nd appears, and all outputs and overflow read 0.

Source files
------------

// File: rtl/summult_if.sv
// summult_if: bus bundle for the summult complex-by-real dot-product pipeline.
//   in_nd    : input set valid this cycle
//   in_m     : sideband metadata that travels with the sample (MWIDTH bits)
//   in_xs    : N complex samples, x_i = in_xs[(i+1)*2*WIDTH-1 -: 2*WIDTH], {re, im}
//   in_ys    : N real signed taps, y_i = in_ys[(i+1)*WIDTH-1 -: WIDTH]
//   out_data : complex result {re, im}
//   out_nd   : out_data/out_m valid this cycle
//   out_m    : in_m delayed alongside its result
//   overflow : sticky overflow flag
// master drives the inputs and observes the results; slave is the design side.
interface summult_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned MWIDTH = 1,
  parameter int unsigned N      = 4
);
  logic                    in_nd;
  logic [MWIDTH-1:0]       in_m;
  logic [N*2*WIDTH-1:0]    in_xs;
  logic [N*WIDTH-1:0]      in_ys;
  logic [2*WIDTH-1:0]      out_data;
  logic                    out_nd;
  logic [MWIDTH-1:0]       out_m;
  logic                    overflow;

  modport master (
    output in_nd, in_m, in_xs, in_ys,
    input  out_data, out_nd, out_m, overflow
  );

  modport slave (
    input  in_nd, in_m, in_xs, in_ys,
    output out_data, out_nd, out_m, overflow
  );
endinterface

// File: rtl/summult.sv
// summult: computes sum_i(x_i * y_i) for N complex samples x_i and real Q1.(WIDTH-1)
// taps y_i, in three register stages (result valid two edges after capture).
//   clk   : clock
//   rst_n : synchronous active-low reset; clears outputs, overflow and all valids
//   bus   : summult_if.slave (in_nd/in_m/in_xs/in_ys in, out_data/out_nd/out_m/overflow out)
// Optional feature: define SUMMULT_SATURATE_EN to clamp out-of-range components;
// otherwise out-of-range components wrap to their low WIDTH bits. The sticky
// overflow flag behaves the same in both builds.
module summult #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned MWIDTH = 1,
  parameter int unsigned N      = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  summult_if.slave  bus
);

  localparam int unsigned XW  = 2 * WIDTH;          // one complex sample
  localparam int unsigned PW  = 2 * WIDTH;          // exact product width
  localparam int unsigned LGN = $clog2(N);          // growth of an N-term sum
  localparam int unsigned SW  = PW + LGN;           // exact sum width
  localparam int unsigned SH  = WIDTH - 1;          // Q1.(WIDTH-1) rescale

  // True when a shifted sum is representable in WIDTH signed bits.
  function automatic logic fits(input logic signed [SW-1:0] v);
    return (v[SW-1:WIDTH-1] == '0) || (v[SW-1:WIDTH-1] == '1);
  endfunction

  // Reduce a shifted sum to WIDTH bits: clamp or wrap when it does not fit.
  function automatic logic [WIDTH-1:0] narrow(input logic signed [SW-1:0] v);
`ifdef SUMMULT_SATURATE_EN
    if (!fits(v)) begin
      if (v[SW-1]) return {1'b1, {(WIDTH-1){1'b0}}};
      else         return {1'b0, {(WIDTH-1){1'b1}}};
    end
    return v[WIDTH-1:0];
`else
    return v[WIDTH-1:0];
`endif
  endfunction

  // Tap unpacking and exact per-tap products.
  logic signed [WIDTH-1:0] x_re [N];
  logic signed [WIDTH-1:0] x_im [N];
  logic signed [WIDTH-1:0] y_t  [N];
  logic signed [PW-1:0]    prod_re_d [N];
  logic signed [PW-1:0]    prod_im_d [N];

  for (genvar g = 0; g < N; g++) begin : g_tap
    assign x_re[g]      = bus.in_xs[(g+1)*XW-1 -: WIDTH];
    assign x_im[g]      = bus.in_xs[g*XW+WIDTH-1 -: WIDTH];
    assign y_t[g]       = bus.in_ys[(g+1)*WIDTH-1 -: WIDTH];
    assign prod_re_d[g] = PW'(x_re[g]) * PW'(y_t[g]);
    assign prod_im_d[g] = PW'(x_im[g]) * PW'(y_t[g]);
  end

  // Stage 0: capture products of an accepted input set.
  logic                  v0;
  logic [MWIDTH-1:0]     m0;
  logic signed [PW-1:0]  prod_re_q [N];
  logic signed [PW-1:0]  prod_im_q [N];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      m0 <= '0;
      for (int i = 0; i < int'(N); i++) begin
        prod_re_q[i] <= '0;
        prod_im_q[i] <= '0;
      end
    end else begin
      v0 <= bus.in_nd;
      if (bus.in_nd) begin
        m0 <= bus.in_m;
        for (int i = 0; i < int'(N); i++) begin
          prod_re_q[i] <= prod_re_d[i];
          prod_im_q[i] <= prod_im_d[i];
        end
      end
    end
  end

  // Stage 1: exact full-precision sums of the products.
  logic signed [SW-1:0] sum_re_d, sum_im_d;

  always_comb begin
    sum_re_d = '0;
    sum_im_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum_re_d = sum_re_d + SW'(prod_re_q[i]);
      sum_im_d = sum_im_d + SW'(prod_im_q[i]);
    end
  end

  logic                 v1;
  logic [MWIDTH-1:0]    m1;
  logic signed [SW-1:0] sum_re_q, sum_im_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      m1       <= '0;
      sum_re_q <= '0;
      sum_im_q <= '0;
    end else begin
      v1 <= v0;
      if (v0) begin
        m1       <= m0;
        sum_re_q <= sum_re_d;
        sum_im_q <= sum_im_d;
      end
    end
  end

  // Stage 2: floor-rescale, range check and narrow to WIDTH bits.
  logic signed [SW-1:0] sh_re, sh_im;
  logic                 fit_re, fit_im;
  logic [WIDTH-1:0]     res_re, res_im;

  always_comb begin
    sh_re  = sum_re_q >>> SH;
    sh_im  = sum_im_q >>> SH;
    fit_re = fits(sh_re);
    fit_im = fits(sh_im);
    res_re = narrow(sh_re);
    res_im = narrow(sh_im);
  end

  logic                 out_nd_q;
  logic [2*WIDTH-1:0]   out_data_q;
  logic [MWIDTH-1:0]    out_m_q;
  logic                 overflow_q;

  // Output register; data and metadata hold between valid results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_nd_q   <= 1'b0;
      out_data_q <= '0;
      out_m_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      out_nd_q <= v1;
      if (v1) begin
        out_data_q <= {res_re, res_im};
        out_m_q    <= m1;
      end
      overflow_q <= overflow_q | (v1 & ~(fit_re & fit_im));
    end
  end

  assign bus.out_nd   = out_nd_q;
  assign bus.out_data = out_data_q;
  assign bus.out_m    = out_m_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_summult.sv
// tb_summult: directed plus randomized checks of summult (WIDTH=16, N=4, MWIDTH=1)
// against an integer-arithmetic reference model and an expected-result queue.
module tb_summult;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned MWIDTH = 1;
  localparam int unsigned N      = 4;

  logic clk;
  logic rst_n;

  summult_if #(.WIDTH(WIDTH), .MWIDTH(MWIDTH), .N(N)) bus ();

  summult #(.WIDTH(WIDTH), .MWIDTH(MWIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        m;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic        chk_en = 1'b0;
  logic [31:0] last_data = '0;
  logic        last_m = 1'b0;
  logic        model_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reduce an exact rescaled component to 16 bits.
  function automatic logic [15:0] reduce(input longint v);
`ifdef SUMMULT_SATURATE_EN
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  // Reference: plain integer dot products, floor division by 2^15.
  function automatic exp_t model(input logic [127:0] xs, input logic [63:0] ys, input logic m);
    exp_t   e;
    longint sr = 0;
    longint si = 0;
    for (int i = 0; i < 4; i++) begin
      sr += longint'($signed(xs[i*32+31 -: 16])) * longint'($signed(ys[i*16+15 -: 16]));
      si += longint'($signed(xs[i*32+15 -: 16])) * longint'($signed(ys[i*16+15 -: 16]));
    end
    sr = sr >>> 15;
    si = si >>> 15;
    e.ovf  = (sr > 32767) || (sr < -32768) || (si > 32767) || (si < -32768);
    e.data = {reduce(sr), reduce(si)};
    e.m    = m;
    e.due  = 0;
    return e;
  endfunction

  // Output monitor: every valid result must match the queue head on time;
  // otherwise outputs must hold, and overflow must track the sticky model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.out_nd === 1'b1) begin
        chk("unexpected_out_nd", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          chk("out_data", bus.out_data, mon_e.data);
          chk("out_m", 32'(bus.out_m), 32'(mon_e.m));
          chk("latency", 32'(cyc), 32'(mon_e.due));
          last_data = mon_e.data;
          last_m    = mon_e.m;
          if (mon_e.ovf) model_ovf = 1'b1;
        end
      end else begin
        chk("out_nd_known", 32'(bus.out_nd), 32'd0);
        chk("hold_data", bus.out_data, last_data);
        chk("hold_m", 32'(bus.out_m), 32'(last_m));
      end
      chk("overflow", 32'(bus.overflow), 32'(model_ovf));
    end
  end

  task automatic drive(input logic nd, input logic [127:0] xs, input logic [63:0] ys,
                       input logic m, input logic push);
    exp_t e;
    bus.in_nd = nd;
    bus.in_xs = xs;
    bus.in_ys = ys;
    bus.in_m  = m;
    if (nd && push) begin
      e     = model(xs, ys, m);
      e.due = cyc + 3;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      drive(1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom},
            1'($urandom), 1'b0);
  endtask

  task automatic drain();
    for (int t = 0; t < 10 && q.size() != 0; t++) idle(1);
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset(input int k);
    bus.in_nd = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    last_data = '0;
    last_m    = 1'b0;
    model_ovf = 1'b0;
    for (int i = 1; i < k; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] all_x(input logic [15:0] re, input logic [15:0] im);
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = {re, im};
    return v;
  endfunction

  function automatic logic [63:0] all_y(input logic [15:0] y);
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = y;
    return v;
  endfunction

  function automatic logic [127:0] small_x();
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'($urandom_range(0, 8000)) - 16'd4000;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.in_nd = 1'b0;
    bus.in_m  = '0;
    bus.in_xs = '0;
    bus.in_ys = '0;

    // Reset state, with in_nd asserted to show it is ignored under reset.
    bus.in_nd = 1'b1;
    bus.in_xs = all_x(16'd1000, 16'd1000);
    bus.in_ys = all_y(16'd16384);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("reset_out_nd", 32'(bus.out_nd), 32'd0);
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_out_m", 32'(bus.out_m), 32'd0);
    chk("reset_overflow", 32'(bus.overflow), 32'd0);
    chk_en = 1'b1;
    bus.in_nd = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // Basic scaling: all x=(1000,-2000), y=0.5.
    drive(1'b1, all_x(16'd1000, -16'sd2000), all_y(16'd16384), 1'b1, 1'b1);
    idle(2);
    chk("basic_out_nd", 32'(bus.out_nd), 32'd1);
    chk("basic_out_data", bus.out_data, {16'd2000, 16'hf060});
    chk("basic_out_m", 32'(bus.out_m), 32'd1);
    chk("basic_overflow", 32'(bus.overflow), 32'd0);
    idle(2);

    // Floor truncation: x0=(-1,1), y0=1, other taps zero.
    drive(1'b1, {96'd0, 16'hffff, 16'h0001}, {48'd0, 16'd1}, 1'b0, 1'b1);
    idle(2);
    chk("floor_out_data", bus.out_data, {16'hffff, 16'h0000});
    idle(2);

    // Back-to-back inputs with alternating metadata.
    drive(1'b1, all_x(16'd300, 16'd7), all_y(16'd20000), 1'b1, 1'b1);
    drive(1'b1, all_x(-16'sd1234, 16'd4321), all_y(16'd9999), 1'b0, 1'b1);
    drive(1'b1, all_x(16'd32000, -16'sd32000), all_y(-16'sd5000), 1'b1, 1'b1);
    drain();

    // Random in-range traffic with random idle gaps.
    for (int n = 0; n < 40; n++) begin
      drive(1'b1, small_x(), {$urandom, $urandom}, 1'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();
    chk("no_overflow_in_range", 32'(bus.overflow), 32'd0);

    // Overflow: all x=(32767,0), y=32767.
    drive(1'b1, all_x(16'd32767, 16'd0), all_y(16'd32767), 1'b0, 1'b1);
    idle(2);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
`ifdef SUMMULT_SATURATE_EN
    chk("ovf_real", 32'(bus.out_data[31:16]), 32'h7fff);
`else
    chk("ovf_real", 32'(bus.out_data[31:16]), 32'hfff8);
`endif
    chk("ovf_imag", 32'(bus.out_data[15:0]), 32'h0000);
    idle(3);
    drive(1'b1, all_x(16'd10, 16'd10), all_y(16'd10), 1'b1, 1'b1);
    drain();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Random full-range traffic, back to back.
    for (int n = 0; n < 40; n++)
      drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom},
            1'($urandom), 1'b1);
    drain();

    // Reset one cycle after an accepted input: it must never emerge.
    drive(1'b1, all_x(16'd1000, -16'sd2000), all_y(16'd16384), 1'b1, 1'b0);
    do_reset(2);
    idle(5);
    chk("abort_out_nd", 32'(bus.out_nd), 32'd0);
    chk("abort_out_data", bus.out_data, 32'd0);
    chk("abort_out_m", 32'(bus.out_m), 32'd0);
    chk("abort_overflow", 32'(bus.overflow), 32'd0);

    // First input after release is accepted normally.
    drive(1'b1, all_x(-16'sd500, 16'd250), all_y(16'd32767), 1'b1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
